// File: rtl/nmr_bstrm_arb_ctrl.sv
// Sequencer for the NMR arbitrary-bitstream datapath: walks command words in the
// sequence RAM and hands them to the datapath, one word per buffer-ready pulse.
module nmr_bstrm_arb_ctrl #(
    parameter int DATA_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SEQ_START,
    input  logic                    SEQ_ABORT,
    input  logic [ADDR_WIDTH-1:0]   SEQ_START_ADDR,
    output logic [ADDR_WIDTH-1:0]   MEM_ADDR,
    output logic                    MEM_RD,
    input  logic [DATA_WIDTH+3:0]   MEM_RDATA,
    output logic                    DPATH_START,
    output logic                    DPATH_RST,
    input  logic                    DPATH_BUF_RDY,
    input  logic                    DPATH_DONE,
    output logic [DATA_WIDTH-1:0]   DPATH_DATA,
    output logic                    PATTERN_MODE,
    output logic                    ALL_1_MODE,
    output logic                    ALL_0_MODE,
    output logic                    END_OF_SEQUENCE,
    output logic                    BUSY,
    output logic                    SEQ_DONE,
    output logic                    ERR_OVERRUN,
    output logic                    ERR_NOEOS,
    output logic [CNT_WIDTH-1:0]    SEG_COUNT
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ARM, S_RUN, S_RFETCH, S_RLOAD, S_FINISH
    } state_t;

    // {eos, all_0, all_1, pattern}; terminating word has only eos set
    localparam logic [3:0] TERM_MODE = 4'b1000;

    state_t                  state, state_n;
    logic [3:0]              mode, mode_n;
    logic [DATA_WIDTH-1:0]   data_n;
    logic [ADDR_WIDTH-1:0]   start_addr, start_addr_n, mem_addr_n, addr_inc;
    logic [CNT_WIDTH-1:0]    cnt_n, cnt_inc;
    logic [1:0]              arm_cnt, arm_cnt_n;
    logic                    mem_rd_n, dpath_start_n, busy_n, seq_done_n;
    logic                    err_ovr_n, err_noeos_n;
    logic                    dpath_rst_n, rst_hold, rst_hold_n;
    logic                    presented_term;

    assign presented_term = (mode == TERM_MODE);
    assign addr_inc       = MEM_ADDR + ADDR_WIDTH'(1);
    assign cnt_inc        = (&SEG_COUNT) ? SEG_COUNT : SEG_COUNT + CNT_WIDTH'(1);
    assign {END_OF_SEQUENCE, ALL_0_MODE, ALL_1_MODE, PATTERN_MODE} = mode;

    always_comb begin
        state_n       = state;
        mode_n        = mode;
        data_n        = DPATH_DATA;
        start_addr_n  = start_addr;
        mem_addr_n    = MEM_ADDR;
        mem_rd_n      = 1'b0;
        dpath_start_n = 1'b0;
        busy_n        = BUSY;
        seq_done_n    = 1'b0;
        err_ovr_n     = ERR_OVERRUN;
        err_noeos_n   = ERR_NOEOS;
        cnt_n         = SEG_COUNT;
        arm_cnt_n     = arm_cnt;
        dpath_rst_n   = rst_hold;
        rst_hold_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (SEQ_START) begin
                    start_addr_n = SEQ_START_ADDR;
                    mem_addr_n   = SEQ_START_ADDR;
                    mem_rd_n     = 1'b1;
                    err_ovr_n    = 1'b0;
                    err_noeos_n  = 1'b0;
                    cnt_n        = '0;
                    busy_n       = 1'b1;
                    state_n      = S_FETCH;
                end
            end
            S_FETCH: state_n = S_LOAD;
            S_LOAD: begin
                data_n        = MEM_RDATA[DATA_WIDTH-1:0];
                mode_n        = MEM_RDATA[DATA_WIDTH+3 -: 4];
                cnt_n         = cnt_inc;
                dpath_start_n = 1'b1;
                arm_cnt_n     = '0;
                state_n       = S_ARM;
            end
            S_ARM: begin
                // datapath never left DONE after the start pulse: give up
                if (!DPATH_DONE) begin
                    state_n = S_RUN;
                end else if (arm_cnt == 2'd3) begin
                    err_ovr_n = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = S_IDLE;
                end else begin
                    arm_cnt_n = arm_cnt + 2'd1;
                end
            end
            S_RUN: begin
                if (DPATH_BUF_RDY) begin
                    if (presented_term) begin
                        state_n = S_FINISH;
                    end else if (addr_inc == start_addr) begin
                        mem_addr_n  = addr_inc;
                        err_noeos_n = 1'b1;
                        data_n      = '0;
                        mode_n      = TERM_MODE;
                        cnt_n       = cnt_inc;
                        state_n     = S_FINISH;
                    end else begin
                        mem_addr_n = addr_inc;
                        mem_rd_n   = 1'b1;
                        state_n    = S_RFETCH;
                    end
                end
            end
            S_RFETCH: begin
                if (DPATH_BUF_RDY) err_ovr_n = 1'b1;
                state_n = S_RLOAD;
            end
            S_RLOAD: begin
                if (DPATH_BUF_RDY) err_ovr_n = 1'b1;
                data_n  = MEM_RDATA[DATA_WIDTH-1:0];
                mode_n  = MEM_RDATA[DATA_WIDTH+3 -: 4];
                cnt_n   = cnt_inc;
                state_n = S_RUN;
            end
            S_FINISH: begin
                if (DPATH_DONE) begin
                    seq_done_n = 1'b1;
                    busy_n     = 1'b0;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // abort overrides everything once a sequence is under way
        if (SEQ_ABORT && state != S_IDLE) begin
            state_n       = S_IDLE;
            mode_n        = '0;
            mem_rd_n      = 1'b0;
            dpath_start_n = 1'b0;
            busy_n        = 1'b0;
            seq_done_n    = 1'b0;
            dpath_rst_n   = 1'b1;
            rst_hold_n    = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            mode        <= '0;
            DPATH_DATA  <= '0;
            start_addr  <= '0;
            MEM_ADDR    <= '0;
            MEM_RD      <= 1'b0;
            DPATH_START <= 1'b0;
            DPATH_RST   <= 1'b0;
            rst_hold    <= 1'b0;
            BUSY        <= 1'b0;
            SEQ_DONE    <= 1'b0;
            ERR_OVERRUN <= 1'b0;
            ERR_NOEOS   <= 1'b0;
            SEG_COUNT   <= '0;
            arm_cnt     <= '0;
        end else begin
            state       <= state_n;
            mode        <= mode_n;
            DPATH_DATA  <= data_n;
            start_addr  <= start_addr_n;
            MEM_ADDR    <= mem_addr_n;
            MEM_RD      <= mem_rd_n;
            DPATH_START <= dpath_start_n;
            DPATH_RST   <= dpath_rst_n;
            rst_hold    <= rst_hold_n;
            BUSY        <= busy_n;
            SEQ_DONE    <= seq_done_n;
            ERR_OVERRUN <= err_ovr_n;
            ERR_NOEOS   <= err_noeos_n;
            SEG_COUNT   <= cnt_n;
            arm_cnt     <= arm_cnt_n;
        end
    end
endmodule

// File: tb/tb_nmr_bstrm_arb_ctrl.sv
// Bench for nmr_bstrm_arb_ctrl: RAM models, a hand-driven datapath and a word-list
// reference model; a second instance with a 3-bit address covers the wrap case.
module tb_nmr_bstrm_arb_ctrl;
    localparam int DW = 120;
    localparam int AW = 10;
    localparam int CW = 16;
    localparam int WW = DW + 4;
    localparam logic [3:0] TERM = 4'b1000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          go = 1'b0, sel = 1'b0, seq_abort = 1'b0, buf_rdy = 1'b0, dp_done = 1'b1;
    logic [AW-1:0] start_addr = '0;
    int            checks = 0, errors = 0;

    logic [WW-1:0] ram  [1024];
    logic [WW-1:0] ram3 [8];
    logic [WW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr[$];

    logic [AW-1:0] m_addr;  logic m_rd; logic [WW-1:0] m_rdata; logic [DW-1:0] m_data;
    logic m_dstart, m_drst, m_pm, m_a1, m_a0, m_eos, m_busy, m_sdone, m_ovr, m_noeos;
    logic [CW-1:0] m_cnt;
    logic [2:0]    n_addr;  logic n_rd; logic [WW-1:0] n_rdata; logic [DW-1:0] n_data;
    logic n_dstart, n_drst, n_pm, n_a1, n_a0, n_eos, n_busy, n_sdone, n_ovr, n_noeos;
    logic [CW-1:0] n_cnt;

    nmr_bstrm_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
        .CLK(CLK), .RST(RST), .SEQ_START(go & ~sel), .SEQ_ABORT(seq_abort),
        .SEQ_START_ADDR(start_addr), .MEM_ADDR(m_addr), .MEM_RD(m_rd), .MEM_RDATA(m_rdata),
        .DPATH_START(m_dstart), .DPATH_RST(m_drst), .DPATH_BUF_RDY(buf_rdy),
        .DPATH_DONE(dp_done), .DPATH_DATA(m_data), .PATTERN_MODE(m_pm), .ALL_1_MODE(m_a1),
        .ALL_0_MODE(m_a0), .END_OF_SEQUENCE(m_eos), .BUSY(m_busy), .SEQ_DONE(m_sdone),
        .ERR_OVERRUN(m_ovr), .ERR_NOEOS(m_noeos), .SEG_COUNT(m_cnt));

    nmr_bstrm_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .CNT_WIDTH(CW)) u_dut3 (
        .CLK(CLK), .RST(RST), .SEQ_START(go & sel), .SEQ_ABORT(seq_abort),
        .SEQ_START_ADDR(start_addr[2:0]), .MEM_ADDR(n_addr), .MEM_RD(n_rd), .MEM_RDATA(n_rdata),
        .DPATH_START(n_dstart), .DPATH_RST(n_drst), .DPATH_BUF_RDY(buf_rdy),
        .DPATH_DONE(dp_done), .DPATH_DATA(n_data), .PATTERN_MODE(n_pm), .ALL_1_MODE(n_a1),
        .ALL_0_MODE(n_a0), .END_OF_SEQUENCE(n_eos), .BUSY(n_busy), .SEQ_DONE(n_sdone),
        .ERR_OVERRUN(n_ovr), .ERR_NOEOS(n_noeos), .SEG_COUNT(n_cnt));

    always @(posedge CLK) if (m_rd) m_rdata <= ram[m_addr];
    always @(posedge CLK) if (n_rd) n_rdata <= ram3[n_addr];

    // view of whichever instance the current scenario drives
    logic [AW-1:0] s_addr; logic [WW-1:0] s_word; logic [CW-1:0] s_cnt;
    logic s_rd, s_dstart, s_busy, s_sdone, s_ovr, s_noeos;
    assign s_addr   = sel ? AW'(n_addr) : m_addr;
    assign s_word   = sel ? {n_eos, n_a0, n_a1, n_pm, n_data} : {m_eos, m_a0, m_a1, m_pm, m_data};
    assign s_cnt    = sel ? n_cnt : m_cnt;
    assign s_rd     = sel ? n_rd : m_rd;
    assign s_dstart = sel ? n_dstart : m_dstart;
    assign s_busy   = sel ? n_busy : m_busy;
    assign s_sdone  = sel ? n_sdone : m_sdone;
    assign s_ovr    = sel ? n_ovr : m_ovr;
    assign s_noeos  = sel ? n_noeos : m_noeos;

    logic [AW+DW+CW+10:0] m_all;
    logic [3+DW+CW+10:0]  n_all;
    assign m_all = {m_addr, m_rd, m_dstart, m_drst, m_data, m_pm, m_a1, m_a0, m_eos,
                    m_busy, m_sdone, m_ovr, m_noeos, m_cnt};
    assign n_all = {n_addr, n_rd, n_dstart, n_drst, n_data, n_pm, n_a1, n_a0, n_eos,
                    n_busy, n_sdone, n_ovr, n_noeos, n_cnt};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [WW-1:0] rand_word(input bit term);
        logic [127:0] r;
        logic [3:0]   m;
        r = {$urandom, $urandom, $urandom, $urandom};
        m = 4'($urandom);
        if (term) m = TERM;
        else if (m == TERM) m = 4'b1011;
        return {m, r[DW-1:0]};
    endfunction

    // Expected presentation order: walk from start until a terminating word, or
    // until the address comes back round, in which case a forced terminator follows.
    task automatic build_expect(input int start, input int depth, output bit noeos);
        int a;
        logic [WW-1:0] w;
        a = start;
        noeos = 1'b0;
        exp_q.delete();
        exp_addr.delete();
        for (int k = 0; k < depth; k++) begin
            w = sel ? ram3[a % 8] : ram[a];
            exp_q.push_back(w);
            exp_addr.push_back(AW'(a));
            if (w[WW-1:DW] == TERM) return;
            a = (a + 1) % depth;
        end
        noeos = 1'b1;
        exp_q.push_back({TERM, {DW{1'b0}}});
    endtask

    task automatic run_seq(input int start, input int ovr_idx);
        int depth, n;
        bit noeos, ovr;
        depth = sel ? 8 : 1024;
        build_expect(start, depth, noeos);
        n = exp_q.size();
        ovr = 1'b0;
        start_addr = AW'(start);
        go = 1'b1; tick(); go = 1'b0;
        checks++;
        if ({s_busy, s_rd, s_addr, s_cnt, s_ovr, s_noeos} !== {2'b11, AW'(start), CW'(0), 2'b00}) begin
            errors++; $display("FAIL seq_start busy/rd/addr/cnt/err got %h exp %h",
                {s_busy, s_rd, s_addr, s_cnt, s_ovr, s_noeos}, {2'b11, AW'(start), CW'(0), 2'b00});
        end
        tick();
        checks++;
        if ({s_rd, s_dstart} !== 2'b00) begin
            errors++; $display("FAIL fetch rd/dstart got %b exp 00", {s_rd, s_dstart});
        end
        tick();
        checks++;
        if ({s_dstart, s_word, s_cnt} !== {1'b1, exp_q[0], CW'(1)}) begin
            errors++; $display("FAIL first_load got %h exp %h", {s_dstart, s_word, s_cnt}, {1'b1, exp_q[0], CW'(1)});
        end
        dp_done = 1'b0; tick();
        checks++;
        if (s_dstart !== 1'b0) begin
            errors++; $display("FAIL dstart_pulse got %b exp 0", s_dstart);
        end
        for (int i = 0; i < n - 1; i++) begin
            repeat ($urandom_range(1, 4)) tick();
            buf_rdy = 1'b1; tick();
            if (noeos && i == n - 2) begin
                buf_rdy = 1'b0;
                checks++;
                if ({s_word, s_cnt, s_noeos, s_rd} !== {exp_q[i+1], CW'(i + 2), 2'b10}) begin
                    errors++; $display("FAIL forced_word got %h exp %h", {s_word, s_cnt, s_noeos, s_rd},
                        {exp_q[i+1], CW'(i + 2), 2'b10});
                end
            end else begin
                buf_rdy = (i == ovr_idx);
                checks++;
                if ({s_rd, s_addr} !== {1'b1, exp_addr[i+1]}) begin
                    errors++; $display("FAIL refetch rd/addr got %h exp %h", {s_rd, s_addr}, {1'b1, exp_addr[i+1]});
                end
                tick(); buf_rdy = 1'b0;
                if (i == ovr_idx) ovr = 1'b1;
                checks++;
                if (s_word !== exp_q[i]) begin
                    errors++; $display("FAIL early_update word %0d got %h exp %h", i, s_word, exp_q[i]);
                end
                tick();
                checks++;
                if ({s_word, s_cnt, s_ovr} !== {exp_q[i+1], CW'(i + 2), ovr}) begin
                    errors++; $display("FAIL word_update %0d got %h exp %h", i + 1, {s_word, s_cnt, s_ovr},
                        {exp_q[i+1], CW'(i + 2), ovr});
                end
            end
        end
        if (!noeos) begin
            repeat ($urandom_range(1, 4)) tick();
            buf_rdy = 1'b1; tick(); buf_rdy = 1'b0;
            checks++;
            if ({s_rd, s_busy, s_sdone} !== 3'b010) begin
                errors++; $display("FAIL term_finish rd/busy/done got %b exp 010", {s_rd, s_busy, s_sdone});
            end
        end
        repeat ($urandom_range(0, 3)) begin
            tick();
            checks++;
            if ({s_busy, s_sdone} !== 2'b10) begin
                errors++; $display("FAIL finish_wait busy/done got %b exp 10", {s_busy, s_sdone});
            end
        end
        dp_done = 1'b1; tick();
        checks++;
        if ({s_sdone, s_busy, s_cnt, s_ovr, s_noeos, s_word} !== {2'b10, CW'(n), ovr, noeos, exp_q[n-1]}) begin
            errors++; $display("FAIL seq_done got %h exp %h", {s_sdone, s_busy, s_cnt, s_ovr, s_noeos, s_word},
                {2'b10, CW'(n), ovr, noeos, exp_q[n-1]});
        end
        tick();
        checks++;
        if (s_sdone !== 1'b0) begin
            errors++; $display("FAIL seq_done_pulse got %b exp 0", s_sdone);
        end
    endtask

    task automatic test_reset();
        go = 1'b1;
        repeat (3) tick();
        checks++;
        if (m_all !== '0 || n_all !== '0) begin
            errors++; $display("FAIL reset_values got %h / %h exp 0", m_all, n_all);
        end
        go = 1'b0; RST = 1'b0; tick();
        checks++;
        if (m_busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy got %b exp 0", m_busy);
        end
    endtask

    task automatic test_basic();
        ram[4] = {4'b0010, DW'(10)};
        ram[5] = {4'b0001, DW'(8'hA5)};
        ram[6] = {TERM, DW'(0)};
        run_seq(4, -1);
    endtask

    task automatic test_overrun();
        run_seq(4, 0);
        repeat (3) tick();
        checks++;
        if (m_ovr !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky got %b exp 1", m_ovr);
        end
    endtask

    task automatic test_random();
        int start, len;
        for (int it = 0; it < 6; it++) begin
            start = (it == 0) ? 1022 : $urandom_range(0, 1023);
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) ram[(start + k) % 1024] = rand_word(k == len - 1);
            run_seq(start, -1);
        end
    endtask

    task automatic test_noeos();
        sel = 1'b1;
        for (int k = 0; k < 8; k++) ram3[k] = rand_word(1'b0);
        run_seq(0, -1);
        run_seq($urandom_range(1, 7), -1);
        sel = 1'b0;
    endtask

    task automatic test_abort();
        ram[100] = rand_word(1'b0);
        ram[101] = rand_word(1'b0);
        ram[102] = rand_word(1'b1);
        seq_abort = 1'b1; tick(); seq_abort = 1'b0;
        checks++;
        if ({m_drst, m_busy} !== 2'b00) begin
            errors++; $display("FAIL abort_idle_ignored drst/busy got %b exp 00", {m_drst, m_busy});
        end
        start_addr = 100; go = 1'b1; tick(); go = 1'b0; tick(); tick(); dp_done = 1'b0; tick();
        start_addr = 7; go = 1'b1; tick(); go = 1'b0;
        checks++;
        if ({m_busy, m_addr, m_cnt, m_rd} !== {1'b1, AW'(100), CW'(1), 1'b0}) begin
            errors++; $display("FAIL start_while_busy got %h exp %h", {m_busy, m_addr, m_cnt, m_rd},
                {1'b1, AW'(100), CW'(1), 1'b0});
        end
        seq_abort = 1'b1; tick(); seq_abort = 1'b0;
        checks++;
        if ({m_drst, m_busy, m_pm, m_a1, m_a0, m_eos, m_sdone} !== 7'b1000000) begin
            errors++; $display("FAIL abort_1 got %b exp 1000000", {m_drst, m_busy, m_pm, m_a1, m_a0, m_eos, m_sdone});
        end
        tick();
        checks++;
        if ({m_drst, m_busy, m_sdone} !== 3'b100) begin
            errors++; $display("FAIL abort_2 drst/busy/done got %b exp 100", {m_drst, m_busy, m_sdone});
        end
        tick();
        checks++;
        if ({m_drst, m_busy, m_sdone} !== 3'b000) begin
            errors++; $display("FAIL abort_end drst/busy/done got %b exp 000", {m_drst, m_busy, m_sdone});
        end
        dp_done = 1'b1;
        start_addr = 100; go = 1'b1; seq_abort = 1'b1; tick(); go = 1'b0; seq_abort = 1'b0;
        checks++;
        if ({m_busy, m_drst, m_rd} !== 3'b101) begin
            errors++; $display("FAIL start_beats_abort busy/drst/rd got %b exp 101", {m_busy, m_drst, m_rd});
        end
        seq_abort = 1'b1; tick(); seq_abort = 1'b0;
        repeat (2) tick();
        run_seq(100, -1);
    endtask

    task automatic test_arm_timeout();
        start_addr = 100; dp_done = 1'b1;
        go = 1'b1; tick(); go = 1'b0; tick(); tick();
        checks++;
        if (m_dstart !== 1'b1) begin
            errors++; $display("FAIL arm_start got %b exp 1", m_dstart);
        end
        repeat (3) tick();
        checks++;
        if ({m_busy, m_ovr} !== 2'b10) begin
            errors++; $display("FAIL arm_wait busy/ovr got %b exp 10", {m_busy, m_ovr});
        end
        tick();
        checks++;
        if ({m_busy, m_ovr, m_sdone} !== 3'b010) begin
            errors++; $display("FAIL arm_timeout busy/ovr/done got %b exp 010", {m_busy, m_ovr, m_sdone});
        end
    endtask

    task automatic test_rst_mid();
        start_addr = 100; go = 1'b1; tick(); go = 1'b0; tick(); tick(); dp_done = 1'b0; tick();
        repeat (2) tick();
        buf_rdy = 1'b1; tick(); buf_rdy = 1'b0;
        checks++;
        if (m_rd !== 1'b1) begin
            errors++; $display("FAIL rfetch_entry rd got %b exp 1", m_rd);
        end
        go = 1'b1; RST = 1'b1; #1;
        checks++;
        if (m_all !== '0) begin
            errors++; $display("FAIL rst_async got %h exp 0", m_all);
        end
        repeat (2) tick();
        checks++;
        if ({m_busy, m_drst} !== 2'b00) begin
            errors++; $display("FAIL rst_start_ignored busy/drst got %b exp 00", {m_busy, m_drst});
        end
        go = 1'b0; RST = 1'b0; dp_done = 1'b1; repeat (2) tick();
        checks++;
        if ({m_busy, m_addr, m_rd, m_cnt} !== '0) begin
            errors++; $display("FAIL rst_release_idle got %h exp 0", {m_busy, m_addr, m_rd, m_cnt});
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) ram[k] = '0;
        for (int k = 0; k < 8; k++) ram3[k] = '0;
        test_reset();
        test_basic();
        test_overrun();
        test_random();
        test_noeos();
        test_abort();
        test_arm_timeout();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nmr_bstrm_arb_ctrl.md
Name: nmr_bstrm_arb_ctrl

Overview:
Sequencer for the NMR arbitrary-bitstream datapath. It fetches command words from a synchronous sequence RAM starting at a programmed address and presents each word's data and mode flags to the datapath. It starts the datapath and advances one word per datapath buffer-ready pulse. It finishes when the datapath returns DONE after an end-of-sequence word, and reports status and errors to the host.

Parameters:
DATA_WIDTH, 120, datapath data/length field width
ADDR_WIDTH, 10, sequence RAM address width
CNT_WIDTH, 16, segment counter width

Ports:
CLK  in  1  clock
RST  in  1  reset; asynchronous, active-high
SEQ_START  in  1  one-cycle pulse; start sequence (ignored unless idle)
SEQ_ABORT  in  1  one-cycle pulse; abort running sequence
SEQ_START_ADDR  in  ADDR_WIDTH  first word address, sampled on SEQ_START
MEM_ADDR  out  ADDR_WIDTH  RAM read address (registered)
MEM_RD  out  1  RAM read enable (registered)
MEM_RDATA  in  DATA_WIDTH+4  RAM data, valid 1 cycle after the MEM_RD edge
DPATH_START  out  1  one-cycle start pulse to datapath
DPATH_RST  out  1  datapath reset, used for abort
DPATH_BUF_RDY  in  1  datapath has consumed its buffered word
DPATH_DONE  in  1  datapath idle/complete
DPATH_DATA  out  DATA_WIDTH  word bits [DATA_WIDTH-1:0]
PATTERN_MODE  out  1  word bit DATA_WIDTH
ALL_1_MODE  out  1  word bit DATA_WIDTH+1
ALL_0_MODE  out  1  word bit DATA_WIDTH+2
END_OF_SEQUENCE  out  1  word bit DATA_WIDTH+3
BUSY  out  1  sequence in progress
SEQ_DONE  out  1  one-cycle pulse on normal completion
ERR_OVERRUN  out  1  sticky; datapath requested a word before the previous fetch completed
ERR_NOEOS  out  1  sticky; address wrapped without a terminating word
SEG_COUNT  out  CNT_WIDTH  words presented in the current or last sequence

Behaviour:
- Reset values: all outputs 0, except MEM_ADDR = 0. State is IDLE.
- Terminating word: END_OF_SEQUENCE=1 with all three mode bits 0. Mode bits pass through unmodified; the datapath applies its own priority.
- IDLE:
  - SEQ_START: latch SEQ_START_ADDR into MEM_ADDR, MEM_RD=1, clear ERR_*, clear SEG_COUNT, set BUSY, go to FETCH.
- FETCH: MEM_RD=0, go to LOAD.
- LOAD: register MEM_RDATA fields onto the datapath outputs, SEG_COUNT+1, DPATH_START=1 for one cycle, go to ARM.
- ARM: wait for DPATH_DONE=0, then go to RUN. If DPATH_DONE stays 1 for 4 cycles, set ERR_OVERRUN and go to IDLE.
- RUN:
  - DPATH_BUF_RDY=1 and the presented word is non-terminating: MEM_ADDR+1 (wraps at 2^ADDR_WIDTH), MEM_RD=1 for one cycle, go to RFETCH.
  - DPATH_BUF_RDY=1 and the presented word is terminating: go to FINISH.
- RFETCH: one-cycle RAM latency, go to RLOAD.
- RLOAD: register the new word on the datapath outputs, SEG_COUNT+1, go to RUN.
- Update latency: new word is stable on the outputs 2 cycles after the edge that samples DPATH_BUF_RDY. Sequence content must give every segment ≥ 3 datapath cycles; this is a content constraint, not checked beyond the overrun flag.
- Overrun: DPATH_BUF_RDY=1 while in RFETCH or RLOAD sets ERR_OVERRUN; the sequence continues.
- Address wrap: MEM_ADDR wrapping back to SEQ_START_ADDR before a terminating word is presented sets ERR_NOEOS, presents a forced terminating word (all 0s, END_OF_SEQUENCE=1), then goes to FINISH.
- FINISH: wait for DPATH_DONE=1, then SEQ_DONE=1 for one cycle, BUSY=0, go to IDLE. Datapath outputs hold their last values.
- Abort: SEQ_ABORT in any non-IDLE state → DPATH_RST=1 for 2 cycles, mode outputs cleared, BUSY=0, no SEQ_DONE, go to IDLE. SEQ_ABORT in IDLE is ignored.
- Simultaneous SEQ_START and SEQ_ABORT in IDLE: start wins. SEQ_START while BUSY is ignored.
- SEG_COUNT saturates at all-ones.
- RST mid-sequence: immediate return to IDLE with reset values. DPATH_RST is not asserted; the datapath shares RST.

Test Plan:
- RAM[4]=all_1 len 10, RAM[5]=pattern 0xA5, RAM[6]=terminating; SEQ_START_ADDR=4 → DPATH_START one cycle after LOAD, reads at 4,5,6, SEG_COUNT=3, SEQ_DONE after DPATH_DONE rises, no errors.
- DPATH_BUF_RDY pulse in RUN → MEM_RD one cycle later; new DPATH_DATA exactly 2 cycles after the sampling edge.
- Second DPATH_BUF_RDY 1 cycle after the first (segment length 1) → ERR_OVERRUN=1 and stays set until the next SEQ_START.
- ADDR_WIDTH=3, SEQ_START_ADDR=0, no terminating word in RAM → after 8 words ERR_NOEOS=1, forced terminating word presented, SEQ_DONE pulses.
- SEQ_ABORT during RUN → DPATH_RST high exactly 2 cycles, BUSY=0, no SEQ_DONE; a following SEQ_START runs normally.
- RST asserted mid-RFETCH → all outputs at reset values on the same edge; SEQ_START ignored while RST=1.
